// File: rtl/pcs_tx.sv
// rtl/pcs_tx.sv - 1000BASE-X PCS transmit: GMII to code groups with idle, delimiters and K28.5 parity.
// Optional carrier extension (EXT state) is built when PCS_TX_CARRIER_EXT_EN is defined.
module pcs_tx (
    input  logic       clk_125,
    input  logic       reset_n,
    input  logic [7:0] mac_txd,
    input  logic       mac_tx_en,
    input  logic       mac_tx_er,
    input  logic       xcvr_tx_ready,
    output logic [7:0] xcvr_txd,
    output logic       xcvr_tx_datak,
    output logic       tx_even,
    output logic       tx_busy
);

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] CG_S  = 8'hFB;
    localparam logic [7:0] CG_T  = 8'hFD;
    localparam logic [7:0] CG_R  = 8'hF7;
    localparam logic [7:0] CG_V  = 8'hFE;

    typedef enum logic [3:0] {
        IDLE_K, IDLE_D, SOP, DATA, EOP_T, EOP_R, ALIGN_R, DROP
`ifdef PCS_TX_CARRIER_EXT_EN
        , EXT
`endif
    } state_t;

    state_t     r_state;
    state_t     w_nxt;
    state_t     w_idle;
    state_t     w_abort;
    logic       r_even;
    logic [7:0] r_txd;
    logic       r_tx_en;
    logic       r_tx_er;
    logic       r_pend;
    logic       r_ifg_ok;
    logic       r_kseen;
    logic       w_ne;
    logic       w_rise;
    logic       w_want;
    logic       w_ifg_ok;

    // r_state/r_txd describe the slot currently on the outputs; decisions use the
    // GMII inputs being sampled now and the parity of the slot about to start.
    assign w_ne     = ~r_even;
    assign w_rise   = mac_tx_en & ~r_tx_en;
    assign w_want   = mac_tx_en & (w_rise | r_pend);
    assign w_ifg_ok = r_ifg_ok | ((r_state == IDLE_D) & r_kseen);
    assign w_idle   = w_ne ? IDLE_K : IDLE_D;
    assign w_abort  = mac_tx_en ? DROP : w_idle;

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            IDLE_K, IDLE_D: begin
                if (!xcvr_tx_ready && mac_tx_en)
                    w_nxt = DROP;
                else if (w_want && xcvr_tx_ready && w_ifg_ok && w_ne)
                    w_nxt = SOP;
                else
                    w_nxt = w_idle;
            end
            SOP, DATA: begin
                if (!xcvr_tx_ready)
                    w_nxt = w_abort;
                else if (!mac_tx_en)
                    w_nxt = EOP_T;
                else
                    w_nxt = DATA;
            end
            EOP_T: begin
                if (!xcvr_tx_ready) begin
                    w_nxt = w_abort;
                end else begin
                    w_nxt = EOP_R;
`ifdef PCS_TX_CARRIER_EXT_EN
                    if (!mac_tx_en && mac_tx_er)
                        w_nxt = EXT;
`endif
                end
            end
`ifdef PCS_TX_CARRIER_EXT_EN
            EXT: begin
                if (!xcvr_tx_ready)
                    w_nxt = w_abort;
                else if (!mac_tx_en && mac_tx_er)
                    w_nxt = EXT;
                else
                    w_nxt = EOP_R;
            end
`endif
            EOP_R: begin
                if (!xcvr_tx_ready)
                    w_nxt = w_abort;
                else
                    w_nxt = w_ne ? IDLE_K : ALIGN_R;
            end
            ALIGN_R: w_nxt = xcvr_tx_ready ? w_idle : w_abort;
            DROP:    w_nxt = mac_tx_en ? DROP : w_idle;
            default: w_nxt = w_idle;
        endcase
    end

    // r_pend remembers a start that arrived on the wrong parity or inside the
    // inter-frame gap; r_ifg_ok is set once a full K/D idle set has gone out.
    always_ff @(posedge clk_125 or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE_K;
            r_even   <= 1'b1;
            r_txd    <= 8'h00;
            r_tx_en  <= 1'b0;
            r_tx_er  <= 1'b0;
            r_pend   <= 1'b0;
            r_ifg_ok <= 1'b1;
            r_kseen  <= 1'b0;
        end else begin
            r_state  <= w_nxt;
            r_even   <= ~r_even;
            r_txd    <= mac_txd;
            r_tx_en  <= mac_tx_en;
            r_tx_er  <= mac_tx_er;
            r_pend   <= w_want && !(w_nxt inside {SOP, DATA, DROP});
            r_ifg_ok <= (w_nxt == EOP_T) ? 1'b0 : w_ifg_ok;
            r_kseen  <= (r_state == IDLE_K);
        end
    end

    always_comb begin
        xcvr_txd      = K28_5;
        xcvr_tx_datak = 1'b1;
        tx_busy       = 1'b0;
        unique case (r_state)
            IDLE_D: begin
                xcvr_txd      = D16_2;
                xcvr_tx_datak = 1'b0;
            end
            SOP: begin
                xcvr_txd = CG_S;
                tx_busy  = 1'b1;
            end
            DATA: begin
                tx_busy = 1'b1;
                if (r_tx_er) begin
                    xcvr_txd = CG_V;
                end else begin
                    xcvr_txd      = r_txd;
                    xcvr_tx_datak = 1'b0;
                end
            end
            EOP_T: begin
                xcvr_txd = CG_T;
                tx_busy  = 1'b1;
            end
`ifdef PCS_TX_CARRIER_EXT_EN
            EXT: begin
                xcvr_txd = (r_txd == 8'h0F) ? CG_R : CG_V;
                tx_busy  = 1'b1;
            end
`endif
            EOP_R, ALIGN_R: begin
                xcvr_txd = CG_R;
                tx_busy  = 1'b1;
            end
            DROP: begin
                if (!r_even) begin
                    xcvr_txd      = D16_2;
                    xcvr_tx_datak = 1'b0;
                end
            end
            default: begin
                xcvr_txd      = K28_5;
                xcvr_tx_datak = 1'b1;
            end
        endcase
    end

    assign tx_even = r_even;

endmodule
